// File: rtl/mem_request_arbiter.sv
// Arbitrates NUM_REQ pipeline requesters onto the single DMA/cache port.
// Issue/wait handshake per transaction, done pulse, stall and hang timeout.
module mem_request_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDRW   = 32,
   parameter int OPW     = 2,
   parameter int RR_MODE = 0,
   parameter int TIMEOUT = 1023
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*ADDRW-1:0] req_addr,
   input  logic [NUM_REQ*OPW-1:0]   req_op,
   input  logic                     dma_ready,
   input  logic                     rd_valid,
   output logic [ADDRW-1:0]         mem_address,
   output logic [OPW-1:0]           op,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       done,
   output logic                     stall,
   output logic                     busy,
   output logic                     timeout_err
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [IW-1:0] ILAST = IW'(NUM_REQ - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t             state_q;
   logic [ADDRW-1:0]   addr_q;
   logic [OPW-1:0]     op_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [NUM_REQ-1:0] done_q;
   logic [IW-1:0]      win_q;
   logic [IW-1:0]      ptr_q;
   logic [TW-1:0]      cnt_q;
   logic               terr_q;

   logic               found_d;
   logic [IW-1:0]      win_d;
   logic [IW-1:0]      ptr_d;
   logic               expire_d;

   // Search starts at the RR pointer (or 0) and wraps modulo NUM_REQ.
   always_comb begin
      int j;
      j = 0;
      found_d = 1'b0;
      win_d = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (RR_MODE != 0) ? int'(ptr_q) + k : k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found_d && req[IW'(j)]) begin
            found_d = 1'b1;
            win_d = IW'(j);
         end
      end
   end

   assign ptr_d = (win_q == ILAST) ? '0 : win_q + IW'(1);
   assign expire_d = (TIMEOUT != 0) && (cnt_q == TLAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         op_q    <= '0;
         grant_q <= '0;
         done_q  <= '0;
         win_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         done_q <= '0;
         unique case (state_q)
            IDLE: begin
               if (found_d) begin
                  state_q <= ISSUE;
                  addr_q  <= req_addr[win_d*ADDRW +: ADDRW];
                  op_q    <= req_op[win_d*OPW +: OPW];
                  win_q   <= win_d;
                  grant_q <= NUM_REQ'(1) << win_d;
                  cnt_q   <= '0;
               end
            end
            ISSUE: begin
               if (expire_d) begin
                  state_q <= IDLE;
                  addr_q  <= '0;
                  op_q    <= '0;
                  grant_q <= '0;
                  ptr_q   <= ptr_d;
                  terr_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + TW'(1);
                  // rd_valid alongside dma_ready is deliberately dropped.
                  if (dma_ready) begin
                     state_q <= WAIT;
                     addr_q  <= '0;
                     op_q    <= '0;
                  end
               end
            end
            WAIT: begin
               if (rd_valid) begin
                  state_q <= IDLE;
                  done_q  <= grant_q;
                  grant_q <= '0;
                  ptr_q   <= ptr_d;
               end else if (expire_d) begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  ptr_q   <= ptr_d;
                  terr_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + TW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_address = addr_q;
   assign op          = op_q;
   assign grant       = grant_q;
   assign done        = done_q;
   assign busy        = (state_q != IDLE);
   assign timeout_err = terr_q;
   assign stall       = |(req & ~done_q);

endmodule
